bin2bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter. It uses the shift-and-add-3 algorithm (double dabble) and processes one input bit per clock. It generalises the fixed 7-bit hundreds/tens/units split to any input width and digit count, and adds a valid/ready handshake, overflow saturation and a leading-zero mask. It sits between arithmetic/status registers and the 7-segment display driver in the display utilities.

---
 rtl/bin2bcd_seq.sv | 162 ++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// with valid/ready handshake, overflow saturation and a leading-zero mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     nz_mask,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  nz_q, nz_d;
  logic               ovf_out_q, ovf_out_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W:0]     acc_shl_s;
  logic [BIN_W:0]     sh_shl_s;
  logic               carry_s;

  // Add 3 to every digit that is 5 or more; adds stay inside each nibble.
  function automatic logic [ACC_W-1:0] add3_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    logic [3:0]       d;
    r = a;
    for (int k = 0; k < DIGITS; k++) begin
      d = a[4*k +: 4];
      if (d >= 4'd5) begin
        r[4*k +: 4] = d + 4'd3;
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  // Bit k set when digit k or any more significant digit is nonzero.
  function automatic logic [DIGITS-1:0] nz_of(input logic [ACC_W-1:0] a);
    logic [DIGITS-1:0] r;
    logic              seen;
    seen = 1'b0;
    r    = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen = seen | (a[4*k +: 4] != 4'h0);
      r[k] = seen;
    end
    r[0] = 1'b1;
    return r;
  endfunction

  assign acc_adj_s = add3_adjust(acc_q);
  assign acc_shl_s = {acc_adj_s, sh_q[BIN_W-1]};
  assign carry_s   = acc_shl_s[ACC_W];
  assign sh_shl_s  = {sh_q, 1'b0};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign nz_mask   = nz_q;
  assign overflow  = ovf_out_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    nz_d        = nz_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          sh_d    = bin_in;
          acc_d   = {ACC_W{1'b0}};
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = acc_shl_s[ACC_W-1:0];
        sh_d  = sh_shl_s[BIN_W-1:0];
        ovf_d = ovf_q | carry_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          // Sticky overflow includes the bit lost on this final shift.
          if (ovf_q | carry_s) begin
            bcd_d     = {DIGITS{4'h9}};
            nz_d      = {DIGITS{1'b1}};
            ovf_out_d = 1'b1;
          end else begin
            bcd_d     = acc_shl_s[ACC_W-1:0];
            nz_d      = nz_of(acc_shl_s[ACC_W-1:0]);
            ovf_out_d = 1'b0;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      sh_q        <= {BIN_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      bcd_q       <= {ACC_W{1'b0}};
      nz_q        <= DIGITS'(1'b1);
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      nz_q        <= nz_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations (8/3, 10/3, 1/1), table-driven
// vectors, queue scoreboard per instance and hand-written corner sequences.
module tb_bin2bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  nz;
    logic        ovf;
  } exp_t;

  typedef struct {
    int unsigned bin;
    logic [11:0] bcd;
    logic [2:0]  nz;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, ir8, ov8, ovf8;
  logic [7:0]  bin8 = 8'd0;
  logic [11:0] bcd8;
  logic [2:0]  nz8;

  logic        iv10 = 1'b0, ir10, ov10, ovf10;
  logic [9:0]  bin10 = 10'd0;
  logic [11:0] bcd10;
  logic [2:0]  nz10;

  logic        iv1 = 1'b0, ir1, ov1, ovf1;
  logic [0:0]  bin1 = 1'b0;
  logic [3:0]  bcd1;
  logic [0:0]  nz1;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .bin_in(bin8),
    .out_valid(ov8), .bcd(bcd8), .nz_mask(nz8), .overflow(ovf8));

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .bin_in(bin10),
    .out_valid(ov10), .bcd(bcd10), .nz_mask(nz10), .overflow(ovf10));

  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin_in(bin1),
    .out_valid(ov1), .bcd(bcd1), .nz_mask(nz1), .overflow(ovf1));

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q8[$], q10[$], q1[$];
  exp_t e8, e10, e1;
  logic [11:0] hold8 = 12'h000;
  vec_t tbl8[4];
  vec_t tbl10[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent decimal reference for a 3-digit result.
  function automatic exp_t model3(input int unsigned v);
    exp_t r;
    int unsigned h, t, u;
    if (v > 999) begin
      r.bcd = 12'h999; r.nz = 3'b111; r.ovf = 1'b1;
    end else begin
      h = v / 100; t = (v / 10) % 10; u = v % 10;
      r.bcd = {h[3:0], t[3:0], u[3:0]};
      r.nz  = {h != 0, (h != 0) || (t != 0), 1'b1};
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0: return ir8;
      1: return ir10;
      default: return ir1;
    endcase
  endfunction

  function automatic logic ovalid(input int sel);
    case (sel)
      0: return ov8;
      1: return ov10;
      default: return ov1;
    endcase
  endfunction

  task automatic set_iv(input int sel, input logic val);
    case (sel)
      0: iv8 = val;
      1: iv10 = val;
      default: iv1 = val;
    endcase
  endtask

  // One conversion: wait ready, accept, measure edges to out_valid.
  task automatic convert(input int sel, input int unsigned v, input exp_t e, input int lat_exp);
    int waited;
    int lat;
    waited = 0;
    @(negedge clk);
    while (!rdy(sel) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", rdy(sel), 1);
    case (sel)
      0: begin bin8 = v[7:0]; q8.push_back(e); end
      1: begin bin10 = v[9:0]; q10.push_back(e); end
      default: begin bin1 = v[0:0]; q1.push_back(e); end
    endcase
    set_iv(sel, 1'b1);
    @(posedge clk);
    #1;
    set_iv(sel, 1'b0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ovalid(sel) && lat < 40);
    check("latency", lat, lat_exp);
  endtask

  // Scoreboard for the 8/3 instance, plus bcd stability between pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold8 = 12'h000;
    end else if (ov8) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pulse8: got out_valid=1, expected 0 at %0t", $time);
      end else begin
        e8 = q8.pop_front();
        check("bcd8", bcd8, e8.bcd);
        check("nz8", nz8, e8.nz);
        check("ovf8", ovf8, e8.ovf);
      end
      hold8 = bcd8;
    end else begin
      check("bcd8_stable", bcd8, hold8);
    end
  end

  // Scoreboard for the 10/3 instance.
  always @(negedge clk) begin
    if (rst_n && ov10) begin
      if (q10.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pulse10: got out_valid=1, expected 0 at %0t", $time);
      end else begin
        e10 = q10.pop_front();
        check("bcd10", bcd10, e10.bcd);
        check("nz10", nz10, e10.nz);
        check("ovf10", ovf10, e10.ovf);
      end
    end
  end

  // Scoreboard for the 1/1 instance.
  always @(negedge clk) begin
    if (rst_n && ov1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pulse1: got out_valid=1, expected 0 at %0t", $time);
      end else begin
        e1 = q1.pop_front();
        check("bcd1", bcd1, e1.bcd[3:0]);
        check("nz1", nz1, e1.nz[0:0]);
        check("ovf1", ovf1, e1.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int last, lowcnt, edges;

    tbl8[0] = '{bin: 0,    bcd: 12'h000, nz: 3'b001, ovf: 1'b0};
    tbl8[1] = '{bin: 255,  bcd: 12'h255, nz: 3'b111, ovf: 1'b0};
    tbl8[2] = '{bin: 99,   bcd: 12'h099, nz: 3'b011, ovf: 1'b0};
    tbl8[3] = '{bin: 7,    bcd: 12'h007, nz: 3'b001, ovf: 1'b0};
    tbl10[0] = '{bin: 999,  bcd: 12'h999, nz: 3'b111, ovf: 1'b0};
    tbl10[1] = '{bin: 1000, bcd: 12'h999, nz: 3'b111, ovf: 1'b1};
    tbl10[2] = '{bin: 1023, bcd: 12'h999, nz: 3'b111, ovf: 1'b1};
    tbl10[3] = '{bin: 5,    bcd: 12'h005, nz: 3'b001, ovf: 1'b0};

    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_bcd", bcd8, 12'h000);
    check("rst_nz", nz8, 3'b001);
    check("rst_ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      e.bcd = tbl8[i].bcd; e.nz = tbl8[i].nz; e.ovf = tbl8[i].ovf;
      convert(0, tbl8[i].bin, e, 8);
    end
    for (int i = 0; i < 4; i++) begin
      e.bcd = tbl10[i].bcd; e.nz = tbl10[i].nz; e.ovf = tbl10[i].ovf;
      convert(1, tbl10[i].bin, e, 10);
    end

    // Streaming: in_valid held high, bin_in changes every cycle.
    repeat (3) @(negedge clk);
    check("stream_idle", ir8, 1);
    last = -1;
    lowcnt = 0;
    iv8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bin8 = 8'($urandom_range(0, 255));
      if (ir8) begin
        q8.push_back(model3(int'(bin8)));
        if (last >= 0) check("accept_interval", i - last, 10);
        last = i;
      end else begin
        lowcnt++;
      end
      @(negedge clk);
    end
    iv8 = 1'b0;
    check("ready_low_cycles", lowcnt, 45);
    repeat (15) @(negedge clk);

    // Reset in the middle of a conversion.
    bin8 = 8'd200;
    iv8 = 1'b1;
    q8.push_back(model3(200));
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q8.delete();
    check("abort_out_valid", ov8, 0);
    check("abort_bcd", bcd8, 12'h000);
    check("abort_nz", nz8, 3'b001);
    check("abort_ovf", ovf8, 0);
    check("abort_in_ready", ir8, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", ir8, 1);
    repeat (15) @(negedge clk);
    e.bcd = 12'h042; e.nz = 3'b011; e.ovf = 1'b0;
    convert(0, 42, e, 8);

    // BIN_W=1: latency of one edge, back-to-back accepts 3 edges apart.
    e.bcd = 12'h001; e.nz = 3'b001; e.ovf = 1'b0;
    convert(2, 1, e, 1);
    repeat (3) @(negedge clk);
    bin1 = 1'b1;
    iv1 = 1'b1;
    q1.push_back(e);
    @(posedge clk);
    edges = 0;
    do begin
      @(negedge clk);
      if (!ir1) begin
        @(posedge clk);
        edges++;
      end
    end while (!ir1 && edges < 10);
    check("w1_next_accept", edges + 1, 3);
    bin1 = 1'b0;
    e.bcd = 12'h000; e.nz = 3'b001; e.ovf = 1'b0;
    q1.push_back(e);
    @(posedge clk);
    #1 iv1 = 1'b0;
    repeat (6) @(negedge clk);

    check("q8_drained", q8.size(), 0);
    check("q10_drained", q10.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
